// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave cook-cycle controller.
package microondas_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

endpackage

// File: rtl/microondas_tick.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick at terminal count.
module microondas_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= (cnt_reg == TERM) ? '0 : cnt_reg + 1'b1;
        end
    end

    // Not gated by clr: clr is derived from the next state, which itself depends on tick.
    assign tick = en && (cnt_reg == TERM);

endmodule

// File: rtl/microondas_ctrl.sv
// Microwave cook-cycle controller: countdown, magnetron/lamp/beeper drive, start/stop and door interlock.
module microondas_ctrl
    import microondas_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MAX_COUNT  = 21,
    parameter int BEEP_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             door_open,
    output logic             magnetron,
    output logic             lamp,
    output logic             beep,
    output logic [CNT_W-1:0] remaining,
    output logic [2:0]       state_o,
    output logic             done
);

    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
    localparam logic [CNT_W-1:0] SP_MAX = CNT_W'(MAX_COUNT);

    logic [1:0] start_sync, stop_sync, door_sync;
    logic       start_prev, stop_prev;
    logic       start_e, stop_e, door_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= '0;
            stop_sync  <= '0;
            door_sync  <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_btn};
            stop_sync  <= {stop_sync[0], stop_btn};
            door_sync  <= {door_sync[0], door_open};
            start_prev <= start_sync[1];
            stop_prev  <= stop_sync[1];
        end
    end

    assign start_e = start_sync[1] & ~start_prev;
    assign stop_e  = stop_sync[1] & ~stop_prev;
    assign door_s  = door_sync[1];

    logic [CNT_W-1:0] sp;
    assign sp = (count > SP_MAX) ? SP_MAX : count;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] rem_next;
    logic [BW-1:0]    beep_cnt_reg, beep_cnt_next;
    logic             tick, tick_en, tick_clr;

    assign tick_en  = (state_reg == COOK) || (state_reg == DONE);
    assign tick_clr = ((state_next == COOK) && (state_reg != COOK)) ||
                      ((state_next == DONE) && (state_reg != DONE));

    microondas_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_next    = state_reg;
        rem_next      = remaining;
        beep_cnt_next = beep_cnt_reg;
        case (state_reg)
            IDLE: begin
                rem_next = sp;
                if (start_e && !stop_e && !door_s && (sp != '0)) begin
                    state_next = COOK;
                end
            end
            COOK: begin
                if (door_s || stop_e) begin
                    state_next = PAUSE;
                end else if (tick && (remaining != '0)) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next    = DONE;
                        rem_next      = '0;
                        beep_cnt_next = '0;
                    end else begin
                        rem_next = remaining - 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (stop_e) begin
                    state_next = IDLE;
                    rem_next   = sp;
                end else if (start_e && !door_s) begin
                    state_next = COOK;
                end
            end
            DONE: begin
                if (door_s || stop_e) begin
                    state_next = IDLE;
                    rem_next   = sp;
                end else if (tick) begin
                    if (beep_cnt_reg == BEEP_LAST) begin
                        state_next = IDLE;
                        rem_next   = sp;
                    end else begin
                        beep_cnt_next = beep_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                rem_next   = sp;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            remaining    <= '0;
            beep_cnt_reg <= '0;
            magnetron    <= 1'b0;
            lamp         <= 1'b0;
            beep         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            remaining    <= rem_next;
            beep_cnt_reg <= beep_cnt_next;
            magnetron    <= (state_next == COOK);
            lamp         <= (state_next == COOK) || door_s;
            beep         <= (state_next == DONE);
            done         <= (state_reg == COOK) && (state_next == DONE);
        end
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_microondas_ctrl.sv
// Randomized scenario bench for microondas_ctrl against a timing model built from the cook-cycle rules.
module tb_microondas_ctrl;

    localparam int TD   = 4;
    localparam int MAXC = 21;
    localparam int BT   = 3;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COOK  = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] count = 8'd0;
    logic       start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0;
    logic       magnetron, lamp, beep, done;
    logic [7:0] remaining;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    microondas_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MAXC), .BEEP_TICKS(BT)) dut (
        .clk(clk), .rst_n(rst_n), .count(count),
        .start_btn(start_btn), .stop_btn(stop_btn), .door_open(door_open),
        .magnetron(magnetron), .lamp(lamp), .beep(beep),
        .remaining(remaining), .state_o(state_o), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sp_of(input int c);
        return 8'((c > MAXC) ? MAXC : c);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic pulse_stop;
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] sp;
        count = 8'($urandom_range(1, 40));
        sp = sp_of(int'(count));
        cyc(3);
        n_checks++;
        if ({state_o, remaining, magnetron, lamp, beep, done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b, expected all 0",
                     state_o, remaining, magnetron, lamp, beep, done);
        end
        rst_n = 1'b1;
        cyc(1);
        n_checks++;
        if (state_o !== ST_IDLE || remaining !== sp) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d rem=%0d, expected state=0 rem=%0d", state_o, remaining, sp);
        end
        $display("reset: count=%0d sp=%0d", count, sp);
    endtask

    // Full cook cycles: remaining drops every TD clocks, done pulses once, beep lasts BT*TD clocks.
    task automatic test_cook_cycle;
        int         counts[5];
        int         total, ndone;
        logic [7:0] sp, exp_rem;
        logic [2:0] exp_st;
        logic       exp_mag, exp_lamp, exp_beep, exp_done;
        counts[0] = 3;
        counts[1] = 30;
        for (int i = 2; i < 5; i++) counts[i] = $urandom_range(1, 28);
        for (int i = 0; i < 5; i++) begin
            count = 8'(counts[i]);
            sp = sp_of(counts[i]);
            cyc(1);
            n_checks++;
            if (state_o !== ST_IDLE || remaining !== sp) begin
                n_fail++;
                $display("FAIL idle_setpoint: count=%0d rem=%0d state=%0d, expected rem=%0d state=0",
                         count, remaining, state_o, sp);
            end
            pulse_start;
            cyc(2);
            n_checks++;
            if ({state_o, remaining, magnetron, lamp, beep} !== {ST_COOK, sp, 3'b110}) begin
                n_fail++;
                $display("FAIL cook_entry: state=%0d rem=%0d mag=%b lamp=%b beep=%b, expected state=1 rem=%0d mag=1 lamp=1 beep=0",
                         state_o, remaining, magnetron, lamp, beep, sp);
            end
            total = TD * int'(sp) + BT * TD;
            ndone = 0;
            for (int k = 1; k <= total; k++) begin
                @(negedge clk);
                if (k < TD * int'(sp)) begin
                    exp_st = ST_COOK; exp_rem = 8'(int'(sp) - k / TD);
                    exp_mag = 1'b1; exp_lamp = 1'b1; exp_beep = 1'b0; exp_done = 1'b0;
                end else if (k < total) begin
                    exp_st = ST_DONE; exp_rem = 8'd0;
                    exp_mag = 1'b0; exp_lamp = 1'b0; exp_beep = 1'b1; exp_done = (k == TD * int'(sp));
                end else begin
                    exp_st = ST_IDLE; exp_rem = sp;
                    exp_mag = 1'b0; exp_lamp = 1'b0; exp_beep = 1'b0; exp_done = 1'b0;
                end
                if (done === 1'b1) ndone++;
                n_checks++;
                if ({state_o, remaining, magnetron, lamp, beep, done} !==
                    {exp_st, exp_rem, exp_mag, exp_lamp, exp_beep, exp_done}) begin
                    n_fail++;
                    $display("FAIL cook_step k=%0d: state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b, expected state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b",
                             k, state_o, remaining, magnetron, lamp, beep, done,
                             exp_st, exp_rem, exp_mag, exp_lamp, exp_beep, exp_done);
                end
            end
            n_checks++;
            if (ndone != 1) begin
                n_fail++;
                $display("FAIL done_count: saw %0d done pulses, expected 1", ndone);
            end
            $display("cook: count=%0d sp=%0d cycles=%0d done_pulses=%0d", counts[i], sp, total, ndone);
        end
    endtask

    // Door opens mid-cook, pause holds remaining, resume continues from it; then stop pauses.
    task automatic test_door_pause;
        int i;
        count = 8'($urandom_range(6, 21));
        cyc(1);
        pulse_start;
        cyc(2);
        for (i = 0; i < 200 && remaining !== 8'd5; i++) @(negedge clk);
        n_checks++;
        if (remaining !== 8'd5 || state_o !== ST_COOK) begin
            n_fail++;
            $display("FAIL reach_five: rem=%0d state=%0d after %0d cycles, expected rem=5 state=1", remaining, state_o, i);
        end
        door_open = 1'b1;
        cyc(2);
        n_checks++;
        if (magnetron !== 1'b1) begin
            n_fail++;
            $display("FAIL door_early: mag=%b two cycles after door, expected 1", magnetron);
        end
        cyc(1);
        n_checks++;
        if ({state_o, remaining, magnetron, lamp} !== {ST_PAUSE, 8'd5, 2'b01}) begin
            n_fail++;
            $display("FAIL door_pause: state=%0d rem=%0d mag=%b lamp=%b, expected state=2 rem=5 mag=0 lamp=1",
                     state_o, remaining, magnetron, lamp);
        end
        count = 8'($urandom_range(0, 40));
        pulse_start;
        cyc(3);
        n_checks++;
        if (state_o !== ST_PAUSE || remaining !== 8'd5 || magnetron !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_hold: state=%0d rem=%0d mag=%b, expected state=2 rem=5 mag=0", state_o, remaining, magnetron);
        end
        door_open = 1'b0;
        cyc(3);
        n_checks++;
        if (lamp !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_lamp: lamp=%b with door closed, expected 0", lamp);
        end
        pulse_start;
        cyc(2);
        n_checks++;
        if ({state_o, remaining, magnetron} !== {ST_COOK, 8'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL resume: state=%0d rem=%0d mag=%b, expected state=1 rem=5 mag=1", state_o, remaining, magnetron);
        end
        cyc(3);
        n_checks++;
        if (remaining !== 8'd5) begin
            n_fail++;
            $display("FAIL resume_hold: rem=%0d three cycles after resume, expected 5", remaining);
        end
        cyc(1);
        n_checks++;
        if (remaining !== 8'd4) begin
            n_fail++;
            $display("FAIL resume_tick: rem=%0d four cycles after resume, expected 4", remaining);
        end
        pulse_stop;
        cyc(2);
        n_checks++;
        if ({state_o, remaining, magnetron} !== {ST_PAUSE, 8'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_pause: state=%0d rem=%0d mag=%b, expected state=2 rem=4 mag=0", state_o, remaining, magnetron);
        end
        $display("door_pause: paused at 5, resumed, stopped at %0d", remaining);
    endtask

    task automatic test_stop_idle;
        logic [7:0] sp;
        pulse_stop;
        cyc(2);
        sp = sp_of(int'(count));
        n_checks++;
        if (state_o !== ST_IDLE || remaining !== sp) begin
            n_fail++;
            $display("FAIL stop_idle: state=%0d rem=%0d, expected state=0 rem=%0d", state_o, remaining, sp);
        end
        for (int i = 0; i < 4; i++) begin
            count = 8'($urandom_range(0, 60));
            sp = sp_of(int'(count));
            cyc(1);
            n_checks++;
            if (remaining !== sp) begin
                n_fail++;
                $display("FAIL idle_follow: count=%0d rem=%0d, expected %0d", count, remaining, sp);
            end
        end
        count = 8'd0;
        cyc(1);
        pulse_start;
        cyc(3);
        n_checks++;
        if ({state_o, remaining, magnetron} !== {ST_IDLE, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_start: state=%0d rem=%0d mag=%b, expected state=0 rem=0 mag=0", state_o, remaining, magnetron);
        end
        $display("stop_idle: idle follows count, zero setpoint start ignored");
    endtask

    task automatic test_simultaneous;
        count = 8'($urandom_range(2, 21));
        cyc(1);
        pulse_start;
        cyc(2);
        pulse_stop;
        cyc(2);
        n_checks++;
        if (state_o !== ST_PAUSE) begin
            n_fail++;
            $display("FAIL simul_setup: state=%0d, expected 2", state_o);
        end
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        cyc(4);
        n_checks++;
        if (state_o !== ST_IDLE || magnetron !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: state=%0d mag=%b, expected state=0 mag=0", state_o, magnetron);
        end
        door_open = 1'b1;
        cyc(3);
        pulse_start;
        cyc(3);
        n_checks++;
        if ({state_o, magnetron, lamp} !== {ST_IDLE, 2'b01}) begin
            n_fail++;
            $display("FAIL door_open_start: state=%0d mag=%b lamp=%b, expected state=0 mag=0 lamp=1", state_o, magnetron, lamp);
        end
        door_open = 1'b0;
        cyc(3);
        $display("simultaneous: start+stop in pause -> idle, start with door open ignored");
    endtask

    task automatic test_done_abort;
        count = 8'd1;
        cyc(1);
        pulse_start;
        cyc(2);
        cyc(TD);
        n_checks++;
        if ({state_o, beep, done} !== {ST_DONE, 2'b11}) begin
            n_fail++;
            $display("FAIL done_entry: state=%0d beep=%b done=%b, expected state=3 beep=1 done=1", state_o, beep, done);
        end
        door_open = 1'b1;
        cyc(3);
        n_checks++;
        if ({state_o, beep, magnetron, remaining} !== {ST_IDLE, 2'b00, 8'd1}) begin
            n_fail++;
            $display("FAIL done_abort: state=%0d beep=%b mag=%b rem=%0d, expected state=0 beep=0 mag=0 rem=1",
                     state_o, beep, magnetron, remaining);
        end
        door_open = 1'b0;
        cyc(3);
        $display("done_abort: door during beep returns to idle");
    endtask

    task automatic test_reset_mid_cook;
        logic [7:0] sp;
        count = 8'($urandom_range(3, 21));
        sp = sp_of(int'(count));
        cyc(1);
        pulse_start;
        cyc(2);
        cyc($urandom_range(1, 6));
        n_checks++;
        if (magnetron !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_cook: mag=%b, expected 1", magnetron);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state_o, remaining, magnetron, lamp, beep, done} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d rem=%0d mag=%b lamp=%b beep=%b done=%b, expected all 0",
                     state_o, remaining, magnetron, lamp, beep, done);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        n_checks++;
        if (state_o !== ST_IDLE || remaining !== sp || magnetron !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: state=%0d rem=%0d mag=%b, expected state=0 rem=%0d mag=0",
                     state_o, remaining, magnetron, sp);
        end
        $display("reset_mid_cook: sp=%0d", sp);
    endtask

    initial begin
        test_reset;
        test_cook_cycle;
        test_door_pause;
        test_stop_idle;
        test_simultaneous;
        test_done_abort;
        test_reset_mid_cook;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
